// File: rtl/sd_decim_scheduler.sv
// Shared accumulate/dump datapath for NCH sigma-delta streams: round-robin grant of one
// sample per cycle, per-channel decimation by a run-time ratio, results queued in a small FWFT FIFO.
module sd_decim_scheduler #(
  parameter int NCH        = 4,
  parameter int IN_W       = 48,
  parameter int ACC_W      = 48,
  parameter int OUT_W      = 33,
  parameter int RATIO_W    = 10,
  parameter int DEF_RATIO  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     cfg_we,
  input  logic [RATIO_W-1:0]       cfg_ratio,
  output logic                     cfg_err,
  input  logic [NCH-1:0]           in_valid,
  input  logic [NCH*IN_W-1:0]      in_data,
  output logic [NCH-1:0]           in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic [NCH-1:0]           overrun,
  input  logic [NCH-1:0]           ovr_clr,
  output logic                     busy
);
  localparam int CH_W = $clog2(NCH);
  localparam int AW   = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t state_reg, state_next;

  logic [RATIO_W-1:0] ratio_reg;
  logic [CH_W-1:0]    last_reg;
  logic [ACC_W-1:0]   acc_reg [NCH];
  logic [RATIO_W-1:0] cnt_reg [NCH];
  logic [IN_W-1:0]    in_word [NCH];
  logic [NCH-1:0]     overrun_reg;
  logic               cfg_err_reg;

  logic [OUT_W-1:0]   mem_data [FIFO_DEPTH];
  logic [CH_W-1:0]    mem_ch   [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]        fcount_reg;

  logic [NCH-1:0]     grant;
  logic [CH_W-1:0]    grant_idx;
  logic [CH_W:0]      arb_j;
  logic               found;
  logic               accept, dump, push, pop, full, clr_all;
  logic [RATIO_W:0]   cnt_inc;
  logic [ACC_W-1:0]   sum;
  logic [NCH-1:0]     ovr_set;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_unpack
      assign in_word[gi] = in_data[gi*IN_W +: IN_W];
    end
  endgenerate

  // Search starts one past the last granted channel so every requester is served in turn.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    arb_j     = '0;
    for (int k = 1; k <= NCH; k++) begin
      arb_j = {1'b0, last_reg} + (CH_W+1)'(k);
      if (arb_j >= (CH_W+1)'(NCH))
        arb_j = arb_j - (CH_W+1)'(NCH);
      if (!found && in_valid[arb_j[CH_W-1:0]]) begin
        found                    = 1'b1;
        grant[arb_j[CH_W-1:0]]   = 1'b1;
        grant_idx                = arb_j[CH_W-1:0];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (stop)  state_next = S_DRAIN;
      S_DRAIN: if (fcount_reg == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = '0;
    busy     = (state_reg != S_IDLE);
    if (state_reg == S_RUN) in_ready = grant;
  end

  assign accept  = |in_ready;
  assign cnt_inc = {1'b0, cnt_reg[grant_idx]} + {{RATIO_W{1'b0}}, 1'b1};
  assign dump    = accept && (cnt_inc == {1'b0, ratio_reg});
  assign sum     = acc_reg[grant_idx] + ACC_W'(in_word[grant_idx]);
  assign full    = (fcount_reg == (AW+1)'(FIFO_DEPTH));
  assign pop     = out_valid && out_ready;
  assign push    = dump && (!full || pop);
  assign ovr_set = (dump && full && !pop) ? (NCH'(1) << grant_idx) : '0;
  assign clr_all = (state_reg != S_IDLE) && (state_next == S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ratio_reg   <= RATIO_W'(DEF_RATIO);
      cfg_err_reg <= 1'b0;
      last_reg    <= CH_W'(NCH-1);
      overrun_reg <= '0;
    end else begin
      cfg_err_reg <= cfg_we && ((state_reg != S_IDLE) || (cfg_ratio == '0));
      if (cfg_we && (state_reg == S_IDLE) && (cfg_ratio != '0))
        ratio_reg <= cfg_ratio;
      if (accept)
        last_reg <= grant_idx;
      overrun_reg <= (overrun_reg & ~ovr_clr) | ovr_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        acc_reg[c] <= '0;
        cnt_reg[c] <= '0;
      end
    end else if (clr_all) begin
      for (int c = 0; c < NCH; c++) begin
        acc_reg[c] <= '0;
        cnt_reg[c] <= '0;
      end
    end else if (accept) begin
      // A dump clears the channel even when the FIFO had no room for the result.
      acc_reg[grant_idx] <= dump ? '0 : sum;
      cnt_reg[grant_idx] <= dump ? '0 : cnt_inc[RATIO_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_reg] <= sum[ACC_W-1 -: OUT_W];
      mem_ch[wr_ptr_reg]   <= grant_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fcount_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      fcount_reg <= fcount_reg + 1'b1;
      else if (pop && !push) fcount_reg <= fcount_reg - 1'b1;
    end
  end

  // Entry contents are not reset, so the head is masked while the FIFO is empty.
  assign out_valid = (fcount_reg != '0);
  assign out_data  = out_valid ? mem_data[rd_ptr_reg] : '0;
  assign out_ch    = out_valid ? mem_ch[rd_ptr_reg] : '0;
  assign overrun   = overrun_reg;
  assign cfg_err   = cfg_err_reg;
endmodule
